// File: rtl/auto_test_pkg.sv
// Shared definitions for the automatic test sequencer.
//   state_e   : sequencer FSM states
//   CHK_W     : width of the checker verdict vector
//   FREQ..PHASE : bit positions of the individual verdicts in chk_pass
//   cnt_w()   : counter width able to hold 0..max_val
package auto_test_pkg;

  localparam int unsigned CHK_W = 5;

  localparam int unsigned FREQ  = 0;
  localparam int unsigned AMP   = 1;
  localparam int unsigned DUTY  = 2;
  localparam int unsigned THD   = 3;
  localparam int unsigned PHASE = 4;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SETTLE,
    MEASURE,
    NEXT,
    FIN
  } state_e;

  function automatic int unsigned cnt_w(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/auto_test_seq_cnt.sv
// seq_cnt: loadable, saturating down-counter with a terminal (zero) flag.
//   clk, rst_n   : clock, asynchronous active-low reset
//   i_load       : load i_load_val (has priority over i_dec)
//   i_dec        : decrement by one, holding at zero
//   i_load_val   : value to load
//   o_zero       : counter currently equals zero
module seq_cnt #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic             i_dec,
  input  logic [WIDTH-1:0] i_load_val,
  output logic             o_zero
);

  logic [WIDTH-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/auto_test_seq.sv
// auto_test_seq: steps through NUM_PROF test profiles. For each profile it requests a
// checker reload (cfg_valid/cfg_ready), waits SETTLE_CYC cycles, then evaluates NUM_SAMP
// checker verdicts and records a per-profile pass bit plus an accumulated failure code.
//   clk, rst_n   : clock, asynchronous active-low reset
//   start        : pulse, begins a sequence from IDLE
//   abort        : level, terminates a running sequence via FIN
//   param_valid  : chk_pass carries a fresh verdict
//   chk_pass     : per-parameter verdict (freq, amp, duty, THD, phase)
//   cfg_valid    : profile load request; cfg_ready accepts it
//   cfg_idx      : profile index to load
//   busy         : sequence in progress
//   done         : one-cycle pulse at sequence end
//   pass_mask    : per-profile pass result
//   fail_code    : OR of inverted verdicts over all evaluated samples
// Build option: define AUTO_SEQ_TMO_EN to add a per-sample timeout of TMO_CYC cycles.
module auto_test_seq
  import auto_test_pkg::*;
#(
  parameter int unsigned NUM_PROF   = 4,
  parameter int unsigned SETTLE_CYC = 1000,
  parameter int unsigned NUM_SAMP   = 8,
  parameter int unsigned TMO_CYC    = 100000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  input  logic                param_valid,
  input  logic [CHK_W-1:0]    chk_pass,
  output logic                cfg_valid,
  input  logic                cfg_ready,
  output logic [2:0]          cfg_idx,
  output logic                busy,
  output logic                done,
  output logic [NUM_PROF-1:0] pass_mask,
  output logic [CHK_W-1:0]    fail_code
);

  if (NUM_PROF < 1 || NUM_PROF > 8 || NUM_SAMP < 1 || NUM_SAMP > 255 ||
      SETTLE_CYC < 1 || TMO_CYC < 1) begin : g_bad_cfg
    $error("auto_test_seq: parameter out of range");
  end

  // One counter serves settle and timeout, so it is sized for the larger of the two.
`ifdef AUTO_SEQ_TMO_EN
  localparam int unsigned CntMax = (SETTLE_CYC > TMO_CYC) ? SETTLE_CYC : TMO_CYC;
`else
  localparam int unsigned CntMax = SETTLE_CYC;
`endif
  localparam int unsigned CntW  = cnt_w(CntMax);
  localparam int unsigned SampW = cnt_w(NUM_SAMP);

  localparam logic [CntW-1:0]  SettleLd = CntW'(SETTLE_CYC - 1);
  localparam logic [SampW-1:0] LastSamp = SampW'(NUM_SAMP - 1);
  localparam logic [2:0]       LastProf = 3'(NUM_PROF - 1);
`ifdef AUTO_SEQ_TMO_EN
  localparam logic [CntW-1:0]  TmoLd    = CntW'(TMO_CYC - 1);
`endif

  state_e              r_state;
  logic [2:0]          r_idx;
  logic                r_cfg_valid;
  logic                r_busy;
  logic                r_done;
  logic [NUM_PROF-1:0] r_pass_mask;
  logic [CHK_W-1:0]    r_fail_code;
  logic [SampW-1:0]    r_samp_cnt;
  logic                r_prof_ok;

  logic            w_hs;
  logic            w_samp_ok;
  logic            w_last;
  logic            w_cnt_load;
  logic            w_cnt_dec;
  logic [CntW-1:0] w_cnt_val;
  logic            w_cnt_zero;
  logic            w_tmo;

  assign w_hs      = (r_state == LOAD) && r_cfg_valid && cfg_ready;
  assign w_samp_ok = chk_pass[FREQ] & chk_pass[AMP] & chk_pass[DUTY] &
                     chk_pass[THD] & chk_pass[PHASE];
  assign w_last    = (r_samp_cnt == LastSamp);

  // Counter load/decrement. SETTLE lasts exactly SETTLE_CYC cycles because the counter
  // is loaded with SETTLE_CYC-1 on the handshake and SETTLE exits on the zero cycle.
  always_comb begin
    w_cnt_load = 1'b0;
    w_cnt_dec  = 1'b0;
    w_cnt_val  = SettleLd;
    case (r_state)
      LOAD: begin
        w_cnt_load = w_hs;
      end
      SETTLE: begin
`ifdef AUTO_SEQ_TMO_EN
        w_cnt_load = w_cnt_zero;
        w_cnt_val  = TmoLd;
`endif
        w_cnt_dec  = !w_cnt_zero;
      end
`ifdef AUTO_SEQ_TMO_EN
      MEASURE: begin
        w_cnt_load = param_valid;
        w_cnt_val  = TmoLd;
        w_cnt_dec  = !param_valid;
      end
`endif
      default: begin
      end
    endcase
  end

`ifdef AUTO_SEQ_TMO_EN
  assign w_tmo = (r_state == MEASURE) && !param_valid && w_cnt_zero;
`else
  assign w_tmo = 1'b0;
`endif

  seq_cnt #(
    .WIDTH (CntW)
  ) u_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_cnt_load),
    .i_dec      (w_cnt_dec),
    .i_load_val (w_cnt_val),
    .o_zero     (w_cnt_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_idx       <= '0;
      r_cfg_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_pass_mask <= '0;
      r_fail_code <= '0;
      r_samp_cnt  <= '0;
      r_prof_ok   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      // Abort beats everything, including a coincident handshake or final sample.
      if (abort && (r_state != IDLE) && (r_state != FIN)) begin
        r_state     <= FIN;
        r_cfg_valid <= 1'b0;
        r_done      <= 1'b1;
      end else begin
        case (r_state)
          IDLE: begin
            if (start) begin
              r_pass_mask <= '0;
              r_fail_code <= '0;
              r_idx       <= '0;
              r_cfg_valid <= 1'b1;
              r_busy      <= 1'b1;
              r_state     <= LOAD;
            end
          end
          LOAD: begin
            r_samp_cnt <= '0;
            r_prof_ok  <= 1'b1;
            if (w_hs) begin
              r_cfg_valid <= 1'b0;
              r_state     <= SETTLE;
            end
          end
          SETTLE: begin
            if (w_cnt_zero) begin
              r_state <= MEASURE;
            end
          end
          MEASURE: begin
            if (param_valid) begin
              r_samp_cnt  <= r_samp_cnt + 1'b1;
              r_prof_ok   <= r_prof_ok & w_samp_ok;
              r_fail_code <= r_fail_code | ~chk_pass;
              if (w_last) begin
                for (int p = 0; p < int'(NUM_PROF); p++) begin
                  if (r_idx == 3'(p)) begin
                    r_pass_mask[p] <= r_prof_ok & w_samp_ok;
                  end
                end
                r_state <= NEXT;
              end
            end else if (w_tmo) begin
              for (int p = 0; p < int'(NUM_PROF); p++) begin
                if (r_idx == 3'(p)) begin
                  r_pass_mask[p] <= 1'b0;
                end
              end
              r_fail_code <= '1;
              r_state     <= NEXT;
            end
          end
          NEXT: begin
            if (r_idx == LastProf) begin
              r_done  <= 1'b1;
              r_state <= FIN;
            end else begin
              r_idx       <= r_idx + 1'b1;
              r_cfg_valid <= 1'b1;
              r_state     <= LOAD;
            end
          end
          FIN: begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
          default: begin
            r_busy      <= 1'b0;
            r_cfg_valid <= 1'b0;
            r_state     <= IDLE;
          end
        endcase
      end
    end
  end

  assign cfg_valid = r_cfg_valid;
  assign cfg_idx   = r_idx;
  assign busy      = r_busy;
  assign done      = r_done;
  assign pass_mask = r_pass_mask;
  assign fail_code = r_fail_code;

endmodule

// File: tb/tb_auto_test_seq.sv
// Self-checking bench for auto_test_seq: randomized sequences, a reference model that
// derives pass_mask/fail_code from the per-sample verdicts, and a done-triggered
// scoreboard monitor. Define AUTO_SEQ_TMO_EN to also exercise the timeout path.
module tb_auto_test_seq;

  localparam int unsigned NP = 2;
  localparam int unsigned SC = 4;
  localparam int unsigned NS = 2;
`ifdef AUTO_SEQ_TMO_EN
  localparam int unsigned TMO = 20;
`else
  localparam int unsigned TMO = 100000;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          param_valid = 1'b0;
  logic [4:0]    chk_pass = 5'h00;
  logic          cfg_ready = 1'b0;
  logic          cfg_valid;
  logic [2:0]    cfg_idx;
  logic          busy;
  logic          done;
  logic [NP-1:0] pass_mask;
  logic [4:0]    fail_code;

  auto_test_seq #(
    .NUM_PROF   (NP),
    .SETTLE_CYC (SC),
    .NUM_SAMP   (NS),
    .TMO_CYC    (TMO)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .abort       (abort),
    .param_valid (param_valid),
    .chk_pass    (chk_pass),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_idx     (cfg_idx),
    .busy        (busy),
    .done        (done),
    .pass_mask   (pass_mask),
    .fail_code   (fail_code)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [NP-1:0] mask;
    logic [4:0]    fc;
  } exp_t;

  exp_t       exp_q[$];
  int         n_checks = 0;
  int         n_errors = 0;
  logic [4:0] prof_chk [NP][NS];
  int         rdy_dly [NP];
  logic       prev_done = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference: a profile passes when all its samples are all-ones; the failure code is
  // the OR of every inverted verdict taken; a timed-out profile fails and forces 5'h1F;
  // profiles at or after an abort contribute nothing.
  function automatic exp_t model(input int abort_prof, input int no_samp_prof);
    exp_t e;
    int   lim;
    logic ok;
    e   = '0;
    lim = (abort_prof >= 0) ? abort_prof : int'(NP);
    for (int p = 0; p < lim; p++) begin
      if (p == no_samp_prof) begin
        e.fc = 5'h1F;
      end else begin
        ok = 1'b1;
        for (int s = 0; s < int'(NS); s++) begin
          ok   = ok && (prof_chk[p][s] == 5'h1F);
          e.fc = e.fc | ~prof_chk[p][s];
        end
        e.mask[p] = ok;
      end
    end
    return e;
  endfunction

  // Scoreboard monitor: one expectation consumed per done pulse.
  always @(negedge clk) begin : mon
    exp_t e;
    if (rst_n) begin
      if (prev_done) begin
        chk("done_single_cycle", 32'(done), 32'd0);
        chk("busy_after_done", 32'(busy), 32'd0);
      end else if (done) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 32'(done), 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("pass_mask", 32'(pass_mask), 32'(e.mask));
          chk("fail_code", 32'(fail_code), 32'(e.fc));
        end
      end
      prev_done <= done;
    end else begin
      prev_done <= 1'b0;
    end
  end

  task automatic wait_cfg_valid(input int p);
    int i = 0;
    while (!cfg_valid && i < 300) begin
      @(negedge clk);
      i++;
    end
    chk("cfg_valid_seen", 32'(cfg_valid), 32'd1);
    chk("cfg_idx", 32'(cfg_idx), 32'(p));
  endtask

  task automatic wait_idle();
    int i = 0;
    while (busy && i < 100) begin
      @(negedge clk);
      i++;
    end
    chk("busy_end", 32'(busy), 32'd0);
  endtask

  task automatic run_seq(input exp_t e, input int abort_prof, input int no_samp_prof,
                         input bit start_busy);
    exp_q.push_back(e);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int p = 0; p < int'(NP); p++) begin
      wait_cfg_valid(p);
      for (int d = 0; d < rdy_dly[p]; d++) begin
        @(negedge clk);
        chk("cfg_valid_hold", 32'(cfg_valid), 32'd1);
        chk("cfg_idx_hold", 32'(cfg_idx), 32'(p));
      end
      cfg_ready = 1'b1;
      @(negedge clk);
      cfg_ready = 1'b0;
      chk("cfg_valid_drop", 32'(cfg_valid), 32'd0);
      // Failing verdicts during the settle window must be ignored.
      param_valid = 1'b1;
      chk_pass    = 5'h00;
      if (p == abort_prof) begin
        @(negedge clk);
        param_valid = 1'b0;
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("done_after_abort", 32'(done), 32'd1);
        wait_idle();
        return;
      end
      repeat (SC) @(negedge clk);
      param_valid = 1'b0;
`ifdef AUTO_SEQ_TMO_EN
      if (p == no_samp_prof) begin
        int lat = 0;
        while (!cfg_valid && busy && lat < 300) begin
          @(negedge clk);
          lat++;
        end
        chk("tmo_latency", 32'(lat), 32'(TMO + 1));
        continue;
      end
`endif
      for (int s = 0; s < int'(NS); s++) begin
        param_valid = 1'b0;
        repeat ($urandom_range(0, 2)) @(negedge clk);
        param_valid = 1'b1;
        chk_pass    = prof_chk[p][s];
        if (start_busy && p == 0 && s == 0) start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
      param_valid = 1'b0;
    end
    wait_idle();
    repeat (2) @(negedge clk);
    chk("mask_hold_idle", 32'(pass_mask), 32'(e.mask));
    chk("fc_hold_idle", 32'(fail_code), 32'(e.fc));
  endtask

  task automatic fill_random();
    for (int p = 0; p < int'(NP); p++) begin
      rdy_dly[p] = $urandom_range(0, 3);
      for (int s = 0; s < int'(NS); s++) begin
        prof_chk[p][s] = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'h1F;
      end
    end
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_errors);
    $fatal(1);
  end

  initial begin : stim
    int ab;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_cfg_valid", 32'(cfg_valid), 32'd0);
    chk("rst_cfg_idx", 32'(cfg_idx), 32'd0);
    chk("rst_pass_mask", 32'(pass_mask), 32'd0);
    chk("rst_fail_code", 32'(fail_code), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // All verdicts pass.
    for (int p = 0; p < int'(NP); p++) begin
      rdy_dly[p] = 0;
      for (int s = 0; s < int'(NS); s++) prof_chk[p][s] = 5'h1F;
    end
    run_seq(model(-1, -1), -1, -1, 1'b0);

    // THD fails on profile 1, sample 2.
    prof_chk[1][1] = 5'h17;
    run_seq(model(-1, -1), -1, -1, 1'b0);

    // Long cfg_ready stall on profile 0.
    fill_random();
    rdy_dly[0] = 10;
    run_seq(model(-1, -1), -1, -1, 1'b0);

    // Abort during settle of profile 1.
    fill_random();
    run_seq(model(1, -1), 1, -1, 1'b0);

    // start while busy is ignored.
    fill_random();
    run_seq(model(-1, -1), -1, -1, 1'b1);

`ifdef AUTO_SEQ_TMO_EN
    fill_random();
    run_seq(model(-1, 0), -1, 0, 1'b0);
`endif

    // Reset in the middle of MEASURE.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_cfg_valid(0);
    cfg_ready = 1'b1;
    @(negedge clk);
    cfg_ready = 1'b0;
    repeat (SC) @(negedge clk);
    param_valid = 1'b1;
    chk_pass    = 5'h00;
    @(negedge clk);
    param_valid = 1'b0;
    chk("fc_before_reset", 32'(fail_code), 32'h1F);
    chk("busy_before_reset", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_cfg_valid", 32'(cfg_valid), 32'd0);
    chk("mid_rst_cfg_idx", 32'(cfg_idx), 32'd0);
    chk("mid_rst_pass_mask", 32'(pass_mask), 32'd0);
    chk("mid_rst_fail_code", 32'(fail_code), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("post_rst_busy", 32'(busy), 32'd0);
    chk("post_rst_cfg_valid", 32'(cfg_valid), 32'd0);

    // Randomized sequences with occasional aborts and spurious starts.
    for (int n = 0; n < 25; n++) begin
      fill_random();
      ab = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, NP - 1)) : -1;
      run_seq(model(ab, -1), ab, -1, 1'($urandom_range(0, 1)));
      repeat ($urandom_range(1, 3)) @(negedge clk);
    end

    repeat (5) @(negedge clk);
    chk("pending_expectations", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
